condicionador_entradas: RTL

Input-conditioning stage that sits directly upstream of principal. It takes the raw board switches (mode select e) and push-buttons (p) and synchronises each one to clk. Each input is debounced against a sample-tick prescaler. The result drives principal's e1,e0,p3..p0 inputs as clean registered levels, with a one-cycle strobe whenever any conditioned level changes.

---
 rtl/condicionador_entradas.sv | 107 ++++++++++
 1 files changed

// File: rtl/condicionador_entradas.sv
// Input conditioning ahead of principal: 2-flop synchronisers, shared tick
// prescaler, per-channel debounce counters and a registered change strobe.
module condicionador_entradas #(
    parameter int unsigned TICK_DIV  = 1000,
    parameter int unsigned DEB_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] e_raw,
    input  logic [3:0] p_raw,
    output logic       e1,
    output logic       e0,
    output logic       p3,
    output logic       p2,
    output logic       p1,
    output logic       p0,
    output logic       changed
);

    localparam int unsigned NCH = 6;
    localparam int unsigned CW  = $clog2(DEB_TICKS);
    // Keep the prescaler at least one bit wide so TICK_DIV=1 still elaborates.
    localparam int unsigned PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

    // Channel order: bit5=e1, bit4=e0, bit3..0=p3..p0.
    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] cond;
    logic [NCH-1:0] mismatch;
    logic [NCH-1:0] update;
    logic [PW-1:0]  pre;
    logic           tick;
    logic [CW-1:0]  cnt [NCH];

    assign raw      = {e_raw, p_raw};
    assign tick     = (pre == PRE_LAST);
    assign mismatch = sync2 ^ cond;

    // Two-flop synchroniser for every raw input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Sample-tick prescaler: counts 0..TICK_DIV-1, tick on the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // A channel adopts its synchronised level on the tick that completes the window.
    always_comb begin
        update = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            update[i] = mismatch[i] && tick && (cnt[i] == CNT_LAST);
        end
    end

    // Debounce counters: any edge without a mismatch restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!mismatch[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (cnt[i] == CNT_LAST) begin
                        cond[i] <= sync2[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

    // Single-cycle strobe whenever any conditioned output takes a new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed <= 1'b0;
        end else begin
            changed <= |update;
        end
    end

    assign {e1, e0, p3, p2, p1, p0} = cond;

endmodule
